// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the multiplexed external bus cycle controller:
// sequencer state encoding, bus phase codes and the default wait limit.
package bus_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AH   = 3'd1,
      ST_AL   = 3'd2,
      ST_DATA = 3'd3,
      ST_ACK  = 3'd4
   } state_t;

   localparam logic [1:0] PH_IDLE = 2'b00;
   localparam logic [1:0] PH_AH   = 2'b01;
   localparam logic [1:0] PH_AL   = 2'b10;
   localparam logic [1:0] PH_DATA = 2'b11;

   localparam int WAIT_LIMIT_DEFAULT = 16;

endpackage

// File: rtl/bus_arbiter.sv
// Two-way arbiter: data requests win, but a waiting fetch is never passed over
// by two consecutive data grants. Remembers the last grant for that purpose.
module bus_arbiter (
   input  logic clk,
   input  logic rst_n,
   input  logic f_req,
   input  logic d_req,
   input  logic grant_en,
   output logic gnt_valid,
   output logic gnt_data
);

   logic last_data_q;
   logic last_data_d;

   always_comb begin
      gnt_valid   = f_req | d_req;
      gnt_data    = d_req & ~(last_data_q & f_req);
      last_data_d = last_data_q;
      if (grant_en && gnt_valid) begin
         last_data_d = gnt_data;
      end
   end

   // Out of reset the last grant counts as fetch, so data wins the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_data_q <= 1'b0;
      end else begin
         last_data_q <= last_data_d;
      end
   end

endmodule

// File: rtl/bus_cycle_controller.sv
// Sequences one access at a time over an 8-bit multiplexed bus:
// address-high, address-low, then data with ready/timeout handling.
module bus_cycle_controller
   import bus_ctrl_pkg::*;
#(
   parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        f_req,
   input  logic [15:0] f_addr,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [15:0] d_addr,
   input  logic [7:0]  d_wdata,
   output logic        f_ack,
   output logic        d_ack,
   output logic [7:0]  rdata,
   output logic        err,
   output logic [7:0]  bus_addr,
   output logic [7:0]  bus_dout,
   output logic [7:0]  bus_oe,
   input  logic [7:0]  bus_din,
   input  logic        bus_rdy,
   output logic [1:0]  bus_phase,
   output logic        bus_we
);

   localparam int CW = $clog2(WAIT_LIMIT + 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_LIMIT - 1);

   state_t        state_q, state_d;
   logic [15:0]   addr_q, addr_d;
   logic          we_q, we_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          is_data_q, is_data_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          err_q, err_d;
   logic [7:0]    rdata_q, rdata_d;

   logic grant_en;
   logic gnt_valid;
   logic gnt_data;

   assign grant_en = (state_q == ST_IDLE);

   bus_arbiter u_arbiter (
      .clk       (clk),
      .rst_n     (rst_n),
      .f_req     (f_req),
      .d_req     (d_req),
      .grant_en  (grant_en),
      .gnt_valid (gnt_valid),
      .gnt_data  (gnt_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         is_data_q  <= 1'b0;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         is_data_q  <= is_data_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      is_data_d  = is_data_q;
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               state_d   = ST_AH;
               is_data_d = gnt_data;
               if (gnt_data) begin
                  addr_d  = d_addr;
                  we_d    = d_we;
                  wdata_d = d_wdata;
               end else begin
                  addr_d  = f_addr;
                  we_d    = 1'b0;
                  wdata_d = 8'h00;
               end
            end
         end
         ST_AH:   state_d = ST_AL;
         ST_AL:   state_d = ST_DATA;
         ST_DATA: begin
            if (bus_rdy) begin
               state_d = ST_ACK;
               if (!we_q) begin
                  rdata_d = bus_din;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + CW'(1);
               // This not-ready cycle is the one that brings the count to the limit.
               if (wait_cnt_q == LAST_WAIT) begin
                  state_d = ST_ACK;
                  err_d   = 1'b1;
                  if (!we_q) begin
                     rdata_d = 8'hFF;
                  end
               end
            end
         end
         ST_ACK: begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
            err_d      = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      f_ack     = 1'b0;
      d_ack     = 1'b0;
      err       = 1'b0;
      bus_addr  = 8'h00;
      bus_dout  = 8'h00;
      bus_oe    = 8'h00;
      bus_phase = PH_IDLE;
      bus_we    = 1'b0;
      case (state_q)
         ST_AH: begin
            bus_phase = PH_AH;
            bus_addr  = addr_q[15:8];
         end
         ST_AL: begin
            bus_phase = PH_AL;
            bus_addr  = addr_q[7:0];
         end
         ST_DATA: begin
            bus_phase = PH_DATA;
            bus_addr  = addr_q[7:0];
            bus_we    = we_q;
            if (we_q) begin
               bus_dout = wdata_q;
               bus_oe   = 8'hFF;
            end
         end
         ST_ACK: begin
            f_ack = ~is_data_q;
            d_ack = is_data_q;
            err   = err_q;
         end
         default: ;
      endcase
   end

   assign rdata = rdata_q;

endmodule
